// File: rtl/fifo_rdlat.sv
// Single-clock FIFO with registered status flags and an L-stage read-data pipeline.
// The read_en strobe leaves the pipeline in the same cycle as its data word.
module fifo_rdlat #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int READ_LATENCY = 4,
  parameter int AF_LEVEL     = FIFO_DEPTH - 2,
  parameter int AE_LEVEL     = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          read_en,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [CW-1:0]           w_count_nxt;
  logic                    r_full;
  logic                    r_empty;
  logic                    r_af;
  logic                    r_ae;
  logic                    r_ovf;
  logic                    r_unf;
  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic [READ_LATENCY-1:0] r_pipe_vld;
  logic [DATA_WIDTH-1:0]   r_pipe_data [READ_LATENCY];

  // Full/empty are the pre-edge occupancy, so there is no push-to-pop bypass.
  assign w_wr_acc = push & ~r_full;
  assign w_rd_acc = pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CW'(1'b1);
      2'b01:   w_count_nxt = r_count - CW'(1'b1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Flags are computed from the next count so they never lag the occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1'b1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
      r_empty <= (w_count_nxt == {CW{1'b0}});
      r_af    <= (w_count_nxt >= CW'(AF_LEVEL));
      r_ae    <= (w_count_nxt <= CW'(AE_LEVEL));
      r_ovf   <= push & r_full;
      r_unf   <= pop & r_empty;
    end
  end

  // Each stage loads data only behind a valid bit, so the output holds its last word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pipe_vld <= {READ_LATENCY{1'b0}};
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pipe_data[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      r_pipe_vld[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_pipe_data[0] <= r_mem[r_rd_ptr];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        if (r_pipe_vld[i-1]) begin
          r_pipe_data[i] <= r_pipe_data[i-1];
        end
      end
    end
  end

  assign data_out     = r_pipe_data[READ_LATENCY-1];
  assign read_en      = r_pipe_vld[READ_LATENCY-1];
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_fifo_rdlat.sv
// Directed bench for fifo_rdlat: main 32x16 L=4 instance plus latency/width variants
// sharing one stimulus bus.
module tb_fifo_rdlat;

  logic        clock = 1'b0;
  logic        reset;
  logic        push;
  logic        pop;
  logic [63:0] din;
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] q[$];

  logic [31:0] m_data_out;
  logic        m_read_en, m_full, m_empty, m_af, m_ae, m_ovf, m_unf;
  logic [4:0]  m_count;
  logic [7:0]  a_data_out;
  logic        a_read_en, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [4:0]  a_count;
  logic [63:0] b_data_out;
  logic        b_read_en, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [4:0]  b_count;
  logic [63:0] c_data_out;
  logic        c_read_en, c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
  logic [4:0]  c_count;

  fifo_rdlat #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .READ_LATENCY(4)) u_main (
    .clock(clock), .reset(reset), .push(push), .data_in(din[31:0]), .pop(pop),
    .data_out(m_data_out), .read_en(m_read_en), .full(m_full), .empty(m_empty),
    .almost_full(m_af), .almost_empty(m_ae), .count(m_count),
    .overflow(m_ovf), .underflow(m_unf));

  fifo_rdlat #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .READ_LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset), .push(push), .data_in(din[7:0]), .pop(pop),
    .data_out(a_data_out), .read_en(a_read_en), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
    .overflow(a_ovf), .underflow(a_unf));

  fifo_rdlat #(.DATA_WIDTH(64), .FIFO_DEPTH(16), .READ_LATENCY(2)) u_l2 (
    .clock(clock), .reset(reset), .push(push), .data_in(din), .pop(pop),
    .data_out(b_data_out), .read_en(b_read_en), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
    .overflow(b_ovf), .underflow(b_unf));

  fifo_rdlat #(.DATA_WIDTH(64), .FIFO_DEPTH(16), .READ_LATENCY(7)) u_l7 (
    .clock(clock), .reset(reset), .push(push), .data_in(din), .pop(pop),
    .data_out(c_data_out), .read_en(c_read_en), .full(c_full), .empty(c_empty),
    .almost_full(c_af), .almost_empty(c_ae), .count(c_count),
    .overflow(c_ovf), .underflow(c_unf));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Advance one edge and match any delivered word against the expected-order queue.
  task automatic tick_collect(input string tag);
    tick();
    if (m_read_en) begin
      if (q.size() > 0) check(tag, {32'h0, m_data_out}, q.pop_front());
      else check({tag, "_spurious"}, {63'h0, m_read_en}, 64'h0);
    end
  endtask

  task automatic sweep_chk(input string tag, input int lat, input int e, input logic ren,
                           input logic [63:0] dout, input logic [63:0] wa, input logic [63:0] wb);
    check({tag, "_ren"}, {63'h0, ren}, {63'h0, (e == lat) || (e == lat + 1)});
    if (e == lat) check({tag, "_d0"}, dout, wa);
    else if (e == lat + 1) check({tag, "_d1"}, dout, wb);
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; din = 64'h0;
    #12;
    check("rst_empty", {63'h0, m_empty}, 64'h1);
    check("rst_ae", {63'h0, m_ae}, 64'h1);
    check("rst_full", {63'h0, m_full}, 64'h0);
    check("rst_af", {63'h0, m_af}, 64'h0);
    check("rst_count", {59'h0, m_count}, 64'h0);
    check("rst_ren", {63'h0, m_read_en}, 64'h0);
    check("rst_dout", {32'h0, m_data_out}, 64'h0);
    reset = 1'b0;

    // Three pushes, three pops, exact L=4 delivery timing
    push = 1'b1; din = 64'h11; tick();
    check("t1_cnt1", {59'h0, m_count}, 64'd1);
    check("t1_empty1", {63'h0, m_empty}, 64'h0);
    check("t1_ae1", {63'h0, m_ae}, 64'h1);
    din = 64'h22; tick();
    check("t1_cnt2", {59'h0, m_count}, 64'd2);
    din = 64'h33; tick();
    check("t1_cnt3", {59'h0, m_count}, 64'd3);
    check("t1_ae3", {63'h0, m_ae}, 64'h0);
    push = 1'b0; pop = 1'b1; tick();
    check("t1_pcnt2", {59'h0, m_count}, 64'd2);
    check("t1_ren_k", {63'h0, m_read_en}, 64'h0);
    tick();
    check("t1_pcnt1", {59'h0, m_count}, 64'd1);
    tick();
    check("t1_pcnt0", {59'h0, m_count}, 64'd0);
    check("t1_empty", {63'h0, m_empty}, 64'h1);
    check("t1_ren_k2", {63'h0, m_read_en}, 64'h0);
    pop = 1'b0; tick();
    check("t1_ren_a", {63'h0, m_read_en}, 64'h1);
    check("t1_d_a", {32'h0, m_data_out}, 64'h11);
    tick();
    check("t1_ren_b", {63'h0, m_read_en}, 64'h1);
    check("t1_d_b", {32'h0, m_data_out}, 64'h22);
    tick();
    check("t1_ren_c", {63'h0, m_read_en}, 64'h1);
    check("t1_d_c", {32'h0, m_data_out}, 64'h33);
    tick();
    check("t1_ren_off", {63'h0, m_read_en}, 64'h0);
    check("t1_d_hold", {32'h0, m_data_out}, 64'h33);

    // Fill to full, overflow, drain in order
    push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = 64'(i); q.push_back(64'(i)); tick();
      check("t2_af", {63'h0, m_af}, {63'h0, (i + 1) >= 14});
      check("t2_full", {63'h0, m_full}, {63'h0, i == 15});
    end
    check("t2_cnt16", {59'h0, m_count}, 64'd16);
    din = 64'hAA; tick();
    check("t2_ovf", {63'h0, m_ovf}, 64'h1);
    check("t2_cnt_hold", {59'h0, m_count}, 64'd16);
    push = 1'b0; tick();
    check("t2_ovf_off", {63'h0, m_ovf}, 64'h0);
    pop = 1'b1;
    repeat (16) tick_collect("t2_drain");
    pop = 1'b0;
    repeat (4) tick_collect("t2_drain");
    check("t2_all_read", 64'(q.size()), 64'h0);
    check("t2_empty", {63'h0, m_empty}, 64'h1);

    // Steady push+pop at count 5, pointers wrap
    push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 64'h100 + 64'(i); q.push_back(din); tick();
    end
    pop = 1'b1;
    for (int i = 5; i < 15; i++) begin
      din = 64'h100 + 64'(i); q.push_back(din); tick_collect("t3_stream");
      check("t3_cnt", {59'h0, m_count}, 64'd5);
    end
    push = 1'b0;
    repeat (5) tick_collect("t3_stream");
    pop = 1'b0;
    repeat (4) tick_collect("t3_stream");
    check("t3_all_read", 64'(q.size()), 64'h0);

    // Push+pop while empty, then push+pop while full
    push = 1'b1; pop = 1'b1; din = 64'h55; tick_collect("t4_e");
    check("t4_unf", {63'h0, m_unf}, 64'h1);
    check("t4_cnt1", {59'h0, m_count}, 64'd1);
    push = 1'b0; pop = 1'b0; tick_collect("t4_e");
    check("t4_unf_off", {63'h0, m_unf}, 64'h0);
    repeat (4) tick_collect("t4_e");
    q.push_back(64'h55);
    push = 1'b1;
    for (int i = 0; i < 15; i++) begin
      din = 64'h60 + 64'(i); q.push_back(din); tick();
    end
    check("t4_full", {63'h0, m_full}, 64'h1);
    pop = 1'b1; din = 64'hEE; tick_collect("t4_f");
    check("t4_ovf", {63'h0, m_ovf}, 64'h1);
    check("t4_cnt15", {59'h0, m_count}, 64'd15);
    check("t4_full_off", {63'h0, m_full}, 64'h0);
    push = 1'b0;
    repeat (15) tick_collect("t4_f");
    pop = 1'b0;
    repeat (4) tick_collect("t4_f");
    check("t4_all_read", 64'(q.size()), 64'h0);
    check("t4_cnt0", {59'h0, m_count}, 64'd0);

    // Asynchronous reset with two reads in flight
    push = 1'b1; din = 64'h77; tick();
    din = 64'h88; tick();
    push = 1'b0; pop = 1'b1; tick(); tick();
    pop = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("t5_ren", {63'h0, m_read_en}, 64'h0);
    check("t5_dout", {32'h0, m_data_out}, 64'h0);
    check("t5_cnt", {59'h0, m_count}, 64'h0);
    check("t5_empty", {63'h0, m_empty}, 64'h1);
    check("t5_ae", {63'h0, m_ae}, 64'h1);
    check("t5_full", {63'h0, m_full}, 64'h0);
    check("t5_af", {63'h0, m_af}, 64'h0);
    #2 reset = 1'b0;
    repeat (6) tick_collect("t5_post");
    push = 1'b1; din = 64'h99; tick();
    push = 1'b0; pop = 1'b1; tick();
    check("t5_k0", {63'h0, m_read_en}, 64'h0);
    pop = 1'b0; tick();
    check("t5_k1", {63'h0, m_read_en}, 64'h0);
    tick();
    check("t5_k2", {63'h0, m_read_en}, 64'h0);
    tick();
    check("t5_k3_ren", {63'h0, m_read_en}, 64'h1);
    check("t5_k3_d", {32'h0, m_data_out}, 64'h99);
    tick();
    check("t5_k4", {63'h0, m_read_en}, 64'h0);

    // Latency/width sweep: two pushes, two back-to-back pops
    reset = 1'b1; #2 reset = 1'b0;
    check("t6_rst_l7", {63'h0, c_empty}, 64'h1);
    push = 1'b1; din = 64'h0123_4567_89AB_CDEF; tick();
    din = 64'hFEDC_BA98_7654_3210; tick();
    push = 1'b0; pop = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 2) pop = 1'b0;
      sweep_chk("t6_l1", 1, e, a_read_en, {56'h0, a_data_out}, 64'hEF, 64'h10);
      sweep_chk("t6_l2", 2, e, b_read_en, b_data_out,
                64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
      sweep_chk("t6_l4", 4, e, m_read_en, {32'h0, m_data_out},
                64'h89AB_CDEF, 64'h7654_3210);
      sweep_chk("t6_l7", 7, e, c_read_en, c_data_out,
                64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rdlat.md
# fifo_rdlat

Parametrised single-clock synchronous FIFO with a configurable read-data pipeline. It generalises the team's one-write / fixed-delay-read FIFO in data width, depth and read latency. It also adds:

- simultaneous push and pop in one cycle
- occupancy count and almost-full / almost-empty thresholds
- overflow / underflow error pulses
- a read-valid strobe exactly aligned with its data word

It sits between `intf_fifo`-style producers and consumers whose read datapath is pipelined by L cycles.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width in bits.
- `FIFO_DEPTH`, 16: number of entries; power of two, ≥ 2.
- `READ_LATENCY`, 4: pipeline stages from accepted pop to `read_en`/`data_out`; ≥ 1.
- `AF_LEVEL`, `FIFO_DEPTH`-2: `almost_full` asserts when count ≥ `AF_LEVEL`.
- `AE_LEVEL`, 2: `almost_empty` asserts when count ≤ `AE_LEVEL`.

Ports:
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `push`  in  1  write request.
- `data_in`  in  `DATA_WIDTH`  write data, sampled on an accepted push.
- `pop`  in  1  read request.
- `data_out`  out  `DATA_WIDTH`  read data, valid when `read_en` = 1.
- `read_en`  out  1  one-cycle strobe per accepted pop, aligned with `data_out`.
- `full`  out  1  count == `FIFO_DEPTH`.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ `AF_LEVEL`.
- `almost_empty`  out  1  count ≤ `AE_LEVEL`.
- `count`  out  $clog2(`FIFO_DEPTH`)+1  current occupancy.
- `overflow`  out  1  one-cycle pulse: push while full.
- `underflow`  out  1  one-cycle pulse: pop while empty.

## Operation
- Push accept (`wr_acc`) = `push` && !`full`. On accept: write `mem[wr_ptr]` ← `data_in`; `wr_ptr` increments.
- Pop accept (`rd_acc`) = `pop` && !`empty`. On accept: stage 1 of the read pipeline captures `mem[rd_ptr]` with a valid bit; `rd_ptr` increments.
- Push and pop are independent; both may be accepted in the same cycle.
- Count update: +1 on `wr_acc` only, −1 on `rd_acc` only, unchanged when both or neither are accepted.
- Pointers are $clog2(`FIFO_DEPTH`) bits and wrap naturally from `FIFO_DEPTH`-1 to 0. No separate wrap logic.
- Full is evaluated before the pop, so push && pop while full accepts only the pop. There is no bypass.
- Empty is evaluated before the push, so push && pop while empty accepts only the push. `data_in` never reaches `data_out` in the same cycle.
- Status flags (`full`, `empty`, `almost_full`, `almost_empty`) are registered and derived from the next-state count. They therefore reflect the occupancy after the current edge, with no extra cycle of lag.
- Error pulses:
  - `overflow` is high for one cycle after an edge with `push` && `full`.
  - `underflow` is high for one cycle after an edge with `pop` && `empty`.
  - Rejected requests change no state.
- Read pipeline:
  - `READ_LATENCY` register stages, each carrying {valid, data}.
  - `read_en` = last-stage valid; `data_out` = last-stage data.
  - Data and valid advance together every cycle, with no stall.
  - `data_out` holds the last delivered word while `read_en` = 0.
- Reset (asynchronous, any time):
  - Clears pointers, `count`, all pipeline valid bits, `overflow`, `underflow`, `data_out` (0), `read_en` (0), `full` (0), `almost_full` (0).
  - Sets `empty` = 1 and `almost_empty` = 1.
  - In-flight reads are discarded. Memory contents are don't-care.

## Timing
- Pop latency: a pop accepted at edge k gives `read_en` = 1 and the valid `data_out` in the cycle following edge k+`READ_LATENCY`-1. With L=1, data appears in the cycle right after the accepting edge.
- Back-to-back pops at edges k, k+1, … produce consecutive `read_en` cycles carrying words in FIFO order.
- Write-to-read: a word pushed at edge k can be popped no earlier than edge k+1, because `empty` falls after edge k.
- `count` and the flags update on the same edge as the accepted operation.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- Reset, then push 0x11,0x22,0x33 on consecutive cycles, then pop 3× (L=4) -> `read_en` high on 3 consecutive cycles, data 0x11,0x22,0x33. First word appears in the cycle after the 4th edge counting from the first accepted pop edge. `count` 3→0; `empty` = 1 after the third pop edge.
- Fill the 16-deep FIFO with 0..15, then push 0xAA -> `full` = 1 and `almost_full` = 1 (count ≥ 14); `overflow` pulses for one cycle; count stays 16. Drain 16 pops -> data reads 0..15 with no 0xAA.
- With count = 5, hold push and pop for 10 cycles -> count stays 5, data stays in FIFO order, and pointers wrap past 15 without loss.
- From empty, push and pop together -> push accepted, pop rejected, `underflow` pulses, count = 1, no `read_en`. While full, push and pop together -> pop accepted, `overflow` pulses, count = 15.
- Assert `reset` mid-cycle with 2 reads in flight -> all outputs go to their reset values immediately with no clock edge; no `read_en` after release; the next push/pop sequence behaves as from power-up.
- Sweep `READ_LATENCY` ∈ {1,2,7} and `DATA_WIDTH` ∈ {8,64} -> pop-to-`read_en` distance equals `READ_LATENCY` edges exactly, and data stays aligned with `read_en`.
